// File: rtl/par_2_ser_pkg.sv
// Shared types and helpers for the parallel-to-serial shift register.
package par_2_ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Bit-index counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    int unsigned c;
    c = $clog2(w);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/par_2_ser_hold_buf.sv
// One-entry hold buffer that parks the next word while the current one shifts out.
module par_2_ser_hold_buf
  import par_2_ser_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load_i,
  input  logic                  take_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end else if (take_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/par_2_ser_shift_reg.sv
// MSB-first parallel-to-serial converter with valid/ready input and a hold
// buffer for gap-free back-to-back words.
module par_2_ser_shift_reg
  import par_2_ser_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic                  dout,
  output logic                  dout_valid,
  output logic                  dout_first,
  output logic                  dout_last,
  output logic                  busy
);

  localparam int unsigned CW = cnt_width(DATA_WIDTH);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  dout_first_q, dout_first_d;
  logic                  dout_last_q, dout_last_d;
  logic                  busy_q, busy_d;

  logic [DATA_WIDTH-1:0] hbuf;
  logic                  hvalid;
  logic                  hb_load, hb_take;
  logic                  hvalid_next;
  logic                  accept;
  logic                  last_bit;

  assign din_ready = resetn && !hvalid;
  assign accept    = din_valid && din_ready;
  assign last_bit  = (cnt_q == CW'(DATA_WIDTH - 1));

  par_2_ser_hold_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_hold_buf (
    .clk    (clk),
    .resetn (resetn),
    .load_i (hb_load),
    .take_i (hb_take),
    .data_i (din),
    .data_o (hbuf),
    .valid_o(hvalid)
  );

  // Next state, next shift contents, and the output values for the next cycle.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    hb_load = 1'b0;
    hb_take = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          sreg_d  = din;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!last_bit) begin
          sreg_d  = sreg_q << 1;
          cnt_d   = cnt_q + CW'(1);
          hb_load = accept;
        end else if (hvalid) begin
          sreg_d  = hbuf;
          hb_take = 1'b1;
          cnt_d   = '0;
        end else if (accept) begin
          sreg_d = din;
          cnt_d  = '0;
        end else begin
          sreg_d  = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        sreg_d  = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    hvalid_next  = hb_load || (hvalid && !hb_take);
    dout_valid_d = (state_d == SHIFT);
    dout_d       = dout_valid_d && sreg_d[DATA_WIDTH-1];
    dout_first_d = dout_valid_d && (cnt_d == '0);
    dout_last_d  = dout_valid_d && (cnt_d == CW'(DATA_WIDTH - 1));
    busy_d       = dout_valid_d || hvalid_next;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      sreg_q       <= '0;
      cnt_q        <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_first_q <= 1'b0;
      dout_last_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_first_q <= dout_first_d;
      dout_last_q  <= dout_last_d;
      busy_q       <= busy_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_first = dout_first_q;
  assign dout_last  = dout_last_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_par_2_ser_shift_reg.sv
// Bench for par_2_ser_shift_reg: bit-queue model of the serial stream plus a
// downstream word reassembler, driven by directed word sequences.
module tb_par_2_ser_shift_reg;

  localparam int W = 16;

  typedef struct packed {
    logic b;
    logic f;
    logic l;
  } sbit_t;

  logic         clk = 1'b0;
  logic         resetn;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         dout;
  logic         dout_valid;
  logic         dout_first;
  logic         dout_last;
  logic         busy;

  par_2_ser_shift_reg #(
    .DATA_WIDTH(W)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_first(dout_first),
    .dout_last (dout_last),
    .busy      (busy)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int run      = 0;
  int max_run  = 0;
  int n_first  = 0;
  int n_last   = 0;

  sbit_t        bq[$];
  logic [W-1:0] sent[$];
  logic [W-1:0] rx_log[$];
  logic [W-1:0] acc_w = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream model: the line shows the head of a bit queue; each edge retires
  // the shown bit, and an accepted word appends its 16 bits MSB first.
  // Input is open whenever at most one word's worth of bits is still queued.
  always @(posedge clk or negedge resetn) begin
    bit rdy;
    if (!resetn) begin
      bq.delete();
      sent.delete();
    end else begin
      rdy = (bq.size() <= W);
      if (bq.size() > 0) void'(bq.pop_front());
      if (din_valid && rdy) begin
        for (int i = 0; i < W; i++) begin
          sbit_t e;
          e.b = din[W-1-i];
          e.f = (i == 0);
          e.l = (i == W - 1);
          bq.push_back(e);
        end
        sent.push_back(din);
        n_acc++;
      end
    end
  end

  // Per-cycle compare plus downstream serial-to-parallel reassembly.
  always @(negedge clk) begin
    sbit_t e;
    bit    has;
    if (!resetn) begin
      check("rst_dout", 32'(dout), 32'd0);
      check("rst_dout_valid", 32'(dout_valid), 32'd0);
      check("rst_dout_first", 32'(dout_first), 32'd0);
      check("rst_dout_last", 32'(dout_last), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_din_ready", 32'(din_ready), 32'd0);
      run = 0;
    end else begin
      has = (bq.size() > 0);
      e   = has ? bq[0] : sbit_t'(3'b000);
      check("dout_valid", 32'(dout_valid), 32'(has));
      check("dout", 32'(dout), 32'(e.b));
      check("dout_first", 32'(dout_first), 32'(e.f));
      check("dout_last", 32'(dout_last), 32'(e.l));
      check("busy", 32'(busy), 32'(has));
      check("din_ready", 32'(din_ready), 32'(bq.size() <= W));
      if (dout_valid) begin
        acc_w = {acc_w[W-2:0], dout};
        run++;
        if (run > max_run) max_run = run;
        if (dout_first) n_first++;
        if (dout_last) begin
          n_last++;
          rx_log.push_back(acc_w);
          check("rx_pending", 32'(sent.size() != 0), 32'd1);
          if (sent.size() != 0) check("rx_word", 32'(acc_w), 32'(sent.pop_front()));
        end
      end else begin
        run = 0;
      end
    end
  end

  // Present a word and keep din_valid high until it is taken.
  task automatic send(input logic [W-1:0] w);
    int  a0;
    bit  got;
    a0        = n_acc;
    got       = 1'b0;
    din       = w;
    din_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (n_acc != a0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_qsize(input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bq.size() == n) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("wait_timeout", 32'd0, 32'd1);
    #1;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy && bq.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
    #1;
  endtask

  function automatic int count_rx(input int from, input logic [W-1:0] w);
    int c;
    c = 0;
    for (int i = from; i < rx_log.size(); i++)
      if (rx_log[i] == w) c++;
    return c;
  endfunction

  initial begin
    int mark;
    resetn    = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    resetn = 1'b1;
    #1;
    check("ready_after_reset", 32'(din_ready), 32'd1);
    check("busy_after_reset", 32'(busy), 32'd0);
    @(negedge clk);
    #1;

    // Single word.
    max_run = 0; n_first = 0; n_last = 0; mark = rx_log.size();
    send(16'hA5C3);
    din_valid = 1'b0;
    wait_idle();
    check("t1_word", 32'(rx_log[rx_log.size()-1]), 32'h0000_A5C3);
    check("t1_run", 32'(max_run), 32'd16);
    check("t1_first_cnt", 32'(n_first), 32'd1);
    check("t1_last_cnt", 32'(n_last), 32'd1);
    check("t1_idle_dout", 32'(dout), 32'd0);

    // Back-to-back through the hold buffer.
    max_run = 0; mark = rx_log.size();
    send(16'h8001);
    send(16'hFFFF);
    send(16'h0000);
    din_valid = 1'b0;
    wait_idle();
    check("t2_run", 32'(max_run), 32'd48);
    check("t2_nwords", 32'(rx_log.size() - mark), 32'd3);
    check("t2_w0", 32'(rx_log[mark]), 32'h0000_8001);
    check("t2_w1", 32'(rx_log[mark+1]), 32'h0000_FFFF);
    check("t2_w2", 32'(rx_log[mark+2]), 32'h0000_0000);

    // Bypass on the last-bit cycle.
    max_run = 0; mark = rx_log.size();
    send(16'h1234);
    din_valid = 1'b0;
    wait_qsize(1);
    check("t3_last_shown", 32'(dout_last), 32'd1);
    send(16'h00FF);
    din_valid = 1'b0;
    wait_idle();
    check("t3_run", 32'(max_run), 32'd32);
    check("t3_w1", 32'(rx_log[mark+1]), 32'h0000_00FF);

    // Backpressure: hold buffer full, stable word held for 10 cycles.
    mark = rx_log.size();
    send(16'h1111);
    send(16'h2222);
    din_valid = 1'b0;
    wait_qsize(W + 4);
    check("t4_blocked", 32'(din_ready), 32'd0);
    din       = 16'h5A5A;
    din_valid = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    din_valid = 1'b0;
    wait_idle();
    check("t4_once", 32'(count_rx(mark, 16'h5A5A)), 32'd1);
    check("t4_nwords", 32'(rx_log.size() - mark), 32'd3);

    // Reset mid-word after 7 bits.
    send(16'hF0F0);
    din_valid = 1'b0;
    wait_qsize(W - 7);
    #1;
    resetn = 1'b0;
    #1;
    check("t5_dout", 32'(dout), 32'd0);
    check("t5_valid", 32'(dout_valid), 32'd0);
    check("t5_first", 32'(dout_first), 32'd0);
    check("t5_last", 32'(dout_last), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_ready", 32'(din_ready), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    #1;
    mark = rx_log.size();
    send(16'h1234);
    din_valid = 1'b0;
    wait_idle();
    check("t5_nwords", 32'(rx_log.size() - mark), 32'd1);
    check("t5_word", 32'(rx_log[rx_log.size()-1]), 32'h0000_1234);

    // Idle gap after a word.
    send(16'h0001);
    din_valid = 1'b0;
    wait_idle();
    check("t6_word", 32'(rx_log[rx_log.size()-1]), 32'h0000_0001);
    repeat (5) begin
      @(negedge clk);
      #1;
      check("t6_valid", 32'(dout_valid), 32'd0);
      check("t6_dout", 32'(dout), 32'd0);
      check("t6_busy", 32'(busy), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
